// File: rtl/p2s_pkg.sv
// Shared types and sizing helpers for the reg32 parallel-to-serial transmitter.
package p2s_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} p2s_state_t;

  localparam int P2S_WIDTH_DEF = 32;
  localparam int P2S_DIV_DEF   = 2;

  // Counter width for a modulus n; a 1-bit counter is kept when n is 1.
  function automatic int p2s_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg32_p2s_if.sv
// Request/serial-link bundle between the register side and the p2s transmitter.
interface reg32_p2s_if
  import p2s_pkg::*;
#(
  parameter int WIDTH = P2S_WIDTH_DEF
) ();

  logic             start;
  logic [WIDTH-1:0] D;
  logic             busy;
  logic             done;
  logic             sclk;
  logic             sdo;
  logic             sload;

  modport master (output start, D, input busy, done, sclk, sdo, sload);
  modport slave  (input start, D, output busy, done, sclk, sdo, sload);

endinterface

// File: rtl/p2s_tick.sv
// Serial-clock divider: pulses o_half on the last cycle of every DIV-cycle window.
module p2s_tick
  import p2s_pkg::*;
#(
  parameter int DIV = P2S_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_half
);

  localparam int            CW   = p2s_cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_half = i_en && (r_cnt == LAST);

endmodule

// File: rtl/reg32_p2s.sv
// Shifts a captured register word out MSB-first on sdo/sclk, then strobes sload.
module reg32_p2s
  import p2s_pkg::*;
#(
  parameter int WIDTH = P2S_WIDTH_DEF,
  parameter int DIV   = P2S_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst,
  reg32_p2s_if.slave  bus
);

  localparam int BCW = p2s_cnt_w(WIDTH);

  p2s_state_t       r_state, w_state;
  logic [WIDTH-1:0] r_sh, w_sh;
  logic [BCW-1:0]   r_bit, w_bit;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_sclk, w_sclk;
  logic             r_sload, w_sload;
  logic             w_half;

  p2s_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state != IDLE),
    .o_half (w_half)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_bit   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sload <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sh    <= w_sh;
      r_bit   <= w_bit;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_sclk  <= w_sclk;
      r_sload <= w_sload;
    end
  end

  // sdo is the shift-register MSB; the final shift empties it so LATCH/IDLE see 0.
  always_comb begin
    w_state = r_state;
    w_sh    = r_sh;
    w_bit   = r_bit;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_sclk  = r_sclk;
    w_sload = r_sload;
    case (r_state)
      IDLE: begin
        w_busy  = 1'b0;
        w_sclk  = 1'b0;
        w_sload = 1'b0;
        if (bus.start) begin
          w_state = SHIFT;
          w_sh    = bus.D;
          w_bit   = BCW'(WIDTH - 1);
          w_busy  = 1'b1;
        end
      end
      SHIFT: begin
        if (w_half) begin
          if (!r_sclk) begin
            w_sclk = 1'b1;
          end else begin
            w_sclk = 1'b0;
            w_sh   = {r_sh[WIDTH-2:0], 1'b0};
            if (r_bit != '0) begin
              w_bit = r_bit - BCW'(1);
            end else begin
              w_state = LATCH;
              w_sload = 1'b1;
            end
          end
        end
      end
      LATCH: begin
        if (w_half) begin
          w_state = IDLE;
          w_sload = 1'b0;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.sclk  = r_sclk;
  assign bus.sdo   = r_sh[WIDTH-1];
  assign bus.sload = r_sload;

endmodule

// File: tb/tb_reg32_p2s.sv
// Directed bench for reg32_p2s: 32-bit/DIV=2 instance plus an 8-bit/DIV=1 instance.
module tb_reg32_p2s;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg32_p2s_if #(.WIDTH(32)) a_if ();
  reg32_p2s_if #(.WIDTH(8))  b_if ();

  reg32_p2s #(.WIDTH(32), .DIV(2)) u_a (.clk(clk), .rst(rst), .bus(a_if));
  reg32_p2s #(.WIDTH(8),  .DIV(1)) u_b (.clk(clk), .rst(rst), .bus(b_if));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Link monitors, sampled mid-cycle on the falling clock edge.
  logic        a_ps = 1'b0, a_pb = 1'b0;
  int          a_rise = 0, a_sload = 0, a_done = 0, a_done_cyc = 0, a_acc_cyc = 0;
  logic [31:0] a_word = '0;
  always @(negedge clk) begin
    if (a_if.sclk === 1'b1 && a_ps !== 1'b1) begin
      a_rise <= a_rise + 1;
      a_word <= {a_word[30:0], a_if.sdo};
    end
    if (a_if.sload === 1'b1) a_sload <= a_sload + 1;
    if (a_if.done === 1'b1) begin
      a_done     <= a_done + 1;
      a_done_cyc <= cyc;
    end
    if (a_if.busy === 1'b1 && a_pb !== 1'b1) a_acc_cyc <= cyc;
    a_ps <= a_if.sclk;
    a_pb <= a_if.busy;
  end

  logic       b_ps = 1'b0, b_pb = 1'b0;
  int         b_rise = 0, b_sload = 0, b_done = 0, b_done_cyc = 0, b_acc_cyc = 0;
  logic [7:0] b_word = '0;
  always @(negedge clk) begin
    if (b_if.sclk === 1'b1 && b_ps !== 1'b1) begin
      b_rise <= b_rise + 1;
      b_word <= {b_word[6:0], b_if.sdo};
    end
    if (b_if.sload === 1'b1) b_sload <= b_sload + 1;
    if (b_if.done === 1'b1) begin
      b_done     <= b_done + 1;
      b_done_cyc <= cyc;
    end
    if (b_if.busy === 1'b1 && b_pb !== 1'b1) b_acc_cyc <= cyc;
    b_ps <= b_if.sclk;
    b_pb <= b_if.busy;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_done(input bit sel_b, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = sel_b ? (b_if.done === 1'b1) : (a_if.done === 1'b1);
    end
    if (!seen) chk(sel_b ? "b_done_timeout" : "a_done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic start_a(input logic [31:0] d);
    @(negedge clk);
    a_if.D     = d;
    a_if.start = 1'b1;
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
  endtask

  task automatic start_b(input logic [7:0] d);
    @(negedge clk);
    b_if.D     = d;
    b_if.start = 1'b1;
    @(posedge clk);
    #1;
    b_if.start = 1'b0;
  endtask

  task automatic chk_idle_a(input string pfx);
    chk({pfx, "_busy"},  32'(a_if.busy),  32'd0);
    chk({pfx, "_done"},  32'(a_if.done),  32'd0);
    chk({pfx, "_sclk"},  32'(a_if.sclk),  32'd0);
    chk({pfx, "_sdo"},   32'(a_if.sdo),   32'd0);
    chk({pfx, "_sload"}, 32'(a_if.sload), 32'd0);
  endtask

  int r0, s0, d0, base, t1;

  initial begin
    rst        = 1'b1;
    a_if.start = 1'b0;
    a_if.D     = '0;
    b_if.start = 1'b0;
    b_if.D     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_a("rst");
    chk("rst_b_sload", 32'(b_if.sload), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single transfer, A5A50F0F
    r0 = a_rise; s0 = a_sload; d0 = a_done;
    start_a(32'hA5A5_0F0F);
    chk("t1_busy_e0", 32'(a_if.busy), 32'd1);
    chk("t1_sdo_e0",  32'(a_if.sdo),  32'd1);
    chk("t1_sclk_e0", 32'(a_if.sclk), 32'd0);
    @(posedge clk); #1;
    chk("t1_sclk_e1", 32'(a_if.sclk), 32'd0);
    @(posedge clk); #1;
    chk("t1_sclk_e2", 32'(a_if.sclk), 32'd1);
    wait_done(1'b0, 300);
    chk("t1_word",     a_word,                 32'hA5A5_0F0F);
    chk("t1_rises",    32'(a_rise - r0),       32'd32);
    chk("t1_sload",    32'(a_sload - s0),      32'd2);
    chk("t1_ndone",    32'(a_done - d0),       32'd1);
    chk("t1_done_edge", 32'(a_done_cyc - a_acc_cyc), 32'd130);
    chk("t1_busy_done", 32'(a_if.busy),        32'd0);

    // Start while busy is ignored
    d0 = a_done;
    start_a(32'h0000_0001);
    base = cyc;
    while (cyc < base + 9) @(negedge clk);
    a_if.D     = 32'hFFFF_FFFF;
    a_if.start = 1'b1;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    chk("t2_busy_e10", 32'(a_if.busy), 32'd1);
    wait_done(1'b0, 300);
    chk("t2_word", a_word, 32'h0000_0001);
    repeat (20) @(negedge clk);
    #1;
    chk("t2_ndone", 32'(a_done - d0), 32'd1);
    chk("t2_idle",  32'(a_if.busy),   32'd0);

    // start held high: back-to-back transfers
    r0 = a_rise;
    @(negedge clk);
    a_if.D     = 32'h1234_5678;
    a_if.start = 1'b1;
    wait_done(1'b0, 300);
    chk("t3_word1",  a_word, 32'h1234_5678);
    chk("t3_edge1",  32'(a_done_cyc - a_acc_cyc), 32'd130);
    t1 = a_done_cyc;
    a_if.D = 32'h8765_4321;
    wait_done(1'b0, 300);
    a_if.start = 1'b0;
    chk("t3_accept_in_done", 32'(a_acc_cyc - t1),  32'd1);
    chk("t3_word2",   a_word,                      32'h8765_4321);
    chk("t3_edge2",   32'(a_done_cyc - a_acc_cyc), 32'd130);
    chk("t3_period",  32'(a_done_cyc - t1),        32'd131);
    chk("t3_rises",   32'(a_rise - r0),            32'd64);
    repeat (4) @(negedge clk);
    #1;
    chk("t3_no_third", 32'(a_if.busy), 32'd0);

    // Reset at edge 50 of a transfer
    s0 = a_sload; d0 = a_done;
    start_a(32'hFFFF_0000);
    base = cyc;
    while (cyc < base + 49) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle_a("t4");
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    #1;
    chk("t4_no_sload", 32'(a_sload - s0), 32'd0);
    chk("t4_no_done",  32'(a_done - d0),  32'd0);
    r0 = a_rise;
    start_a(32'hDEAD_BEEF);
    wait_done(1'b0, 300);
    chk("t4_word",  a_word,                      32'hDEAD_BEEF);
    chk("t4_rises", 32'(a_rise - r0),            32'd32);
    chk("t4_edge",  32'(a_done_cyc - a_acc_cyc), 32'd130);

    // WIDTH=8, DIV=1 instance
    r0 = b_rise; s0 = b_sload; d0 = b_done;
    start_b(8'h81);
    chk("t5_sdo_e0",  32'(b_if.sdo),  32'd1);
    chk("t5_sclk_e0", 32'(b_if.sclk), 32'd0);
    @(posedge clk); #1;
    chk("t5_sclk_e1", 32'(b_if.sclk), 32'd1);
    @(posedge clk); #1;
    chk("t5_sclk_e2", 32'(b_if.sclk), 32'd0);
    @(posedge clk); #1;
    chk("t5_sclk_e3", 32'(b_if.sclk), 32'd1);
    wait_done(1'b1, 100);
    chk("t5_word",  32'(b_word),                 32'h81);
    chk("t5_rises", 32'(b_rise - r0),            32'd8);
    chk("t5_sload", 32'(b_sload - s0),           32'd1);
    chk("t5_ndone", 32'(b_done - d0),            32'd1);
    chk("t5_edge",  32'(b_done_cyc - b_acc_cyc), 32'd17);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
